// File: rtl/debounce_toggle_pulse.sv
// debounce_toggle_pulse
// Conditioning stage in front of the toggle register block. It synchronises a raw
// push-button or strap input to CLK, debounces it with a stability counter, and
// drives the clean level on O. It also drives a one-cycle pulse on invert for each
// accepted rising edge. invert connects straight to Main.invert, so one clean press
// gives exactly one toggle.
//
// Optional build macro: DEBOUNCE_FALL_PULSE_EN
//   When this macro is defined, the module adds a one-cycle pulse for each accepted
//   falling edge. That port is named release_pulse because "release" is a reserved
//   word in SystemVerilog.
//   When the macro is undefined, the port and its logic do not exist.
module debounce_toggle_pulse #(
    parameter int SYNC_STAGES     = 2,     // 2..4
    parameter int DEBOUNCE_CYCLES = 1000,  // 1..2^CNT_W-1
    parameter int CNT_W           = 16
) (
    input  logic CLK,
    input  logic ASYNCRESETN,
    input  logic I,
    output logic O,
    output logic invert
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    output logic release_pulse
`endif
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        PEND_HIGH,
        STABLE_HIGH,
        PEND_LOW
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   o_d;
    logic                   rise_d;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic                   fall_d;
`endif

    // Synchroniser chain: I enters at bit 0, and the FSM sees only the last flop.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and the registered outputs; all clear asynchronously.
    // NOTE: every control flop gets an explicit async reset value; there is no memory array here.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            O       <= 1'b0;
            invert  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            O       <= o_d;
            invert  <= rise_d;
        end
    end

`ifdef DEBOUNCE_FALL_PULSE_EN
    // Registered pulse for an accepted falling edge.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            release_pulse <= 1'b0;
        end else begin
            release_pulse <= fall_d;
        end
    end
`endif

    // Next-state logic. A level change is accepted after DEBOUNCE_CYCLES
    // consecutive matching samples of s.
    // NOTE: defaults come first so that no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = O;
        rise_d  = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
        fall_d  = 1'b0;
`endif
        cnt_inc = cnt_q + CNT_ONE;

        case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        o_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = PEND_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PEND_HIGH: begin
                if (!s) begin
                    // Glitch: drop the pending count, and leave O unchanged.
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    o_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                        o_d     = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                        fall_d  = 1'b1;
`endif
                    end else begin
                        state_d = PEND_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PEND_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    o_d     = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                    fall_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_toggle_pulse.sv
// Testbench for debounce_toggle_pulse.
// The bench uses two instances:
//   - dut4: SYNC_STAGES=2, DEBOUNCE_CYCLES=4
//   - dut1: SYNC_STAGES=2, DEBOUNCE_CYCLES=1
// The stimulus pushes the expected output events into a queue, and each event is
// tagged with the cycle where it must appear. A monitor on the falling edge pops
// one queue entry for each output event the DUT produces and compares the two.
module tb_debounce_toggle_pulse;

    localparam int K_O_RISE = 1;
    localparam int K_O_FALL = 2;
    localparam int K_INV    = 3;
    localparam int K_REL    = 4;

    logic CLK;
    logic ASYNCRESETN;
    logic I4, O4, inv4;
    logic I1, O1, inv1;
`ifdef DEBOUNCE_FALL_PULSE_EN
    logic rel4, rel1;
`endif

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int exp_q0[$];
    int exp_q1[$];
    logic prev_o4 = 1'b0;
    logic prev_o1 = 1'b0;
    int c;

    debounce_toggle_pulse #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(4)
    ) dut4 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I4), .O(O4), .invert(inv4)
`ifdef DEBOUNCE_FALL_PULSE_EN
        , .release_pulse(rel4)
`endif
    );

    debounce_toggle_pulse #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(4)
    ) dut1 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I1), .O(O1), .invert(inv1)
`ifdef DEBOUNCE_FALL_PULSE_EN
        , .release_pulse(rel1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Event code = kind * 1000000 + cycle index of the negedge where it is seen.
    task automatic expect_ev(input int which, input int kind, input int at);
        if (which == 0) exp_q0.push_back(kind * 1000000 + at);
        else            exp_q1.push_back(kind * 1000000 + at);
    endtask

    task automatic expect_rise(input int which, input int at);
        expect_ev(which, K_O_RISE, at);
        expect_ev(which, K_INV, at);
    endtask

    task automatic expect_fall(input int which, input int at);
        expect_ev(which, K_O_FALL, at);
`ifdef DEBOUNCE_FALL_PULSE_EN
        expect_ev(which, K_REL, at);
`endif
    endtask

    task automatic got_event(input int which, input int kind);
        int actual;
        actual = kind * 1000000 + cyc;
        if (which == 0) begin
            if (exp_q0.size() == 0) check("dut4_unexpected_event", actual, 0);
            else                    check("dut4_event", actual, exp_q0.pop_front());
        end else begin
            if (exp_q1.size() == 0) check("dut1_unexpected_event", actual, 0);
            else                    check("dut1_event", actual, exp_q1.pop_front());
        end
    endtask

    // Monitor: turns each O transition and each cycle with a pulse high into an event.
    always @(negedge CLK) begin
        if (!ASYNCRESETN) begin
            prev_o4 <= 1'b0;
            prev_o1 <= 1'b0;
        end else begin
            if (O4 !== prev_o4) got_event(0, O4 ? K_O_RISE : K_O_FALL);
            if (inv4)           got_event(0, K_INV);
            if (O1 !== prev_o1) got_event(1, O1 ? K_O_RISE : K_O_FALL);
            if (inv1)           got_event(1, K_INV);
`ifdef DEBOUNCE_FALL_PULSE_EN
            if (rel4)           got_event(0, K_REL);
            if (rel1)           got_event(1, K_REL);
`endif
            prev_o4 <= O4;
            prev_o1 <= O1;
        end
    end

    initial begin
        ASYNCRESETN = 1'b0;
        I4 = 1'b0;
        I1 = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_O", int'(O4), 0);
        check("rst_invert", int'(inv4), 0);
        check("rst_O_dut1", int'(O1), 0);

        // Reset released with I low: outputs stay quiet.
        ASYNCRESETN = 1'b1;
        repeat (20) @(negedge CLK);
        check("idle_O", int'(O4), 0);
        check("idle_invert", int'(inv4), 0);

        // Clean rise: e0 = c+1, accepted at e5 = c+6.
        c = cyc;
        I4 = 1'b1;
        expect_rise(0, c + 6);
        repeat (10) @(negedge CLK);
        check("rise_O_held", int'(O4), 1);
        check("rise_events_done", exp_q0.size(), 0);

        // Asynchronous clear while O is high.
        #2 ASYNCRESETN = 1'b0;
        #1 check("async_clr_O", int'(O4), 0);
        check("async_clr_invert", int'(inv4), 0);
        I4 = 1'b0;
        repeat (2) @(negedge CLK);
        ASYNCRESETN = 1'b1;
        repeat (5) @(negedge CLK);

        // Glitches that are too short (2 and 3 cycles) are rejected.
        for (int w = 2; w <= 3; w++) begin
            I4 = 1'b1;
            repeat (w) @(negedge CLK);
            I4 = 1'b0;
            repeat (10) @(negedge CLK);
            check("glitch_O", int'(O4), 0);
        end
        check("glitch_events_done", exp_q0.size(), 0);

        // Exactly DEBOUNCE_CYCLES high: accepted, then the fall is accepted 4 cycles later.
        c = cyc;
        I4 = 1'b1;
        expect_rise(0, c + 6);
        repeat (4) @(negedge CLK);
        c = cyc;
        I4 = 1'b0;
        expect_fall(0, c + 6);
        repeat (12) @(negedge CLK);
        check("boundary_O", int'(O4), 0);
        check("boundary_events_done", exp_q0.size(), 0);

        // Held high, low for 10 cycles, then high again.
        c = cyc;
        I4 = 1'b1;
        expect_rise(0, c + 6);
        repeat (10) @(negedge CLK);
        c = cyc;
        I4 = 1'b0;
        expect_fall(0, c + 6);
        repeat (10) @(negedge CLK);
        check("fall_O_low", int'(O4), 0);
        c = cyc;
        I4 = 1'b1;
        expect_rise(0, c + 6);
        repeat (10) @(negedge CLK);
        check("rerise_O", int'(O4), 1);
        c = cyc;
        I4 = 1'b0;
        expect_fall(0, c + 6);
        repeat (10) @(negedge CLK);
        check("refall_events_done", exp_q0.size(), 0);

        // Reset mid-PEND_HIGH (cnt=2); the full latency repeats after release.
        I4 = 1'b1;
        repeat (4) @(negedge CLK);
        #2 ASYNCRESETN = 1'b0;
        #1 check("midpend_rst_O", int'(O4), 0);
        check("midpend_rst_invert", int'(inv4), 0);
        repeat (2) @(negedge CLK);
        ASYNCRESETN = 1'b1;
        c = cyc;
        expect_rise(0, c + 6);
        repeat (12) @(negedge CLK);
        check("midpend_O_after", int'(O4), 1);
        check("midpend_events_done", exp_q0.size(), 0);

        // DEBOUNCE_CYCLES=1: toggle every 3 cycles; each change is accepted 3 edges later.
        for (int k = 0; k < 6; k++) begin
            c = cyc;
            I1 = ~I1;
            if (I1) expect_rise(1, c + 3);
            else    expect_fall(1, c + 3);
            repeat (3) @(negedge CLK);
        end
        repeat (6) @(negedge CLK);
        check("deb1_O_final", int'(O1), 0);
        check("deb1_events_done", exp_q1.size(), 0);
        check("dut4_quiet_events", exp_q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
